// File: rtl/c_sub_pipe.sv
// Pipelined B - A subtractor with wrap / saturate / absolute-difference modes,
// valid/ready flow control and a saturating counter of delivered borrow results.
module c_sub_pipe #(
  parameter int WIDTH   = 15,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [1:0]       iMode,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oS,
  output logic             oBorrow,
  output logic             oSat,
  input  logic             iCntClr,
  output logic [CNT_W-1:0] oBorrowCnt
);

  typedef enum logic [1:0] {
    MODE_WRAP = 2'd0,
    MODE_SAT  = 2'd1,
    MODE_ABS  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] s;
    logic             borrow;
    logic             sat;
  } stage_t;

  stage_t           stage_q [LATENCY];
  stage_t           stage_d [LATENCY];
  stage_t           result;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             en;

  // The whole pipe advances together; a stalled output freezes every stage.
  assign en     = ~stage_q[LATENCY-1].valid | iReady;
  assign diff   = {1'b0, iB} - {1'b0, iA};
  assign borrow = diff[WIDTH];

  always_comb begin
    // NOTE: every field gets a default first so no path through the case infers a latch.
    result        = '0;
    result.valid  = 1'b1;
    result.borrow = borrow;
    case (mode_e'(iMode))
      MODE_SAT: begin
        result.s   = borrow ? '0 : diff[WIDTH-1:0];
        result.sat = borrow;
      end
      MODE_ABS: result.s = borrow ? (iA - iB) : diff[WIDTH-1:0];
      default:  result.s = diff[WIDTH-1:0];
    endcase
  end

  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0].valid = iValid;
      if (iValid) begin
        stage_d[0] = result;
      end
      for (int i = 1; i < LATENCY; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (iCntClr) begin
      cnt_d = '0;
    end else if (oValid && iReady && oBorrow && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      // NOTE: payload is cleared along with the valid bits so oS/oBorrow/oSat read 0 after reset.
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage read its neighbour's pre-edge value.
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oReady     = en;
  assign oValid     = stage_q[LATENCY-1].valid;
  assign oS         = stage_q[LATENCY-1].s;
  assign oBorrow    = stage_q[LATENCY-1].borrow;
  assign oSat       = stage_q[LATENCY-1].sat;
  assign oBorrowCnt = cnt_q;

endmodule

// File: tb/tb_c_sub_pipe.sv
// Bench for c_sub_pipe: three configurations driven from shared stimulus, each
// checked against a queue-based arithmetic model plus directed boundary cases.
module tb_c_sub_pipe;

  localparam int W0 = 15, L0 = 1, C0 = 16;
  localparam int W1 = 15, L1 = 3, C1 = 4;
  localparam int W2 = 64, L2 = 4, C2 = 16;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, cnt_clr;
  logic [1:0]  mode;
  logic [63:0] a, b;

  logic        v0, v1, v2, r0, r1, r2, b0, b1, b2, t0, t1, t2;
  logic [14:0] s0, s1;
  logic [63:0] s2;
  logic [15:0] c0, c2;
  logic [3:0]  c1;

  logic        ov [3];
  logic        ordy [3];
  logic        ob [3];
  logic        osat [3];
  logic [63:0] os [3];
  logic [31:0] ocnt [3];

  always #5 clk = ~clk;

  c_sub_pipe #(.WIDTH(W0), .LATENCY(L0), .CNT_W(C0)) u0 (
    .iClock(clk), .iReset(rst), .iValid(in_valid), .oReady(r0),
    .iA(a[W0-1:0]), .iB(b[W0-1:0]), .iMode(mode), .oValid(v0), .iReady(out_ready),
    .oS(s0), .oBorrow(b0), .oSat(t0), .iCntClr(cnt_clr), .oBorrowCnt(c0));

  c_sub_pipe #(.WIDTH(W1), .LATENCY(L1), .CNT_W(C1)) u1 (
    .iClock(clk), .iReset(rst), .iValid(in_valid), .oReady(r1),
    .iA(a[W1-1:0]), .iB(b[W1-1:0]), .iMode(mode), .oValid(v1), .iReady(out_ready),
    .oS(s1), .oBorrow(b1), .oSat(t1), .iCntClr(cnt_clr), .oBorrowCnt(c1));

  c_sub_pipe #(.WIDTH(W2), .LATENCY(L2), .CNT_W(C2)) u2 (
    .iClock(clk), .iReset(rst), .iValid(in_valid), .oReady(r2),
    .iA(a), .iB(b), .iMode(mode), .oValid(v2), .iReady(out_ready),
    .oS(s2), .oBorrow(b2), .oSat(t2), .iCntClr(cnt_clr), .oBorrowCnt(c2));

  assign ov[0] = v0;  assign ov[1] = v1;  assign ov[2] = v2;
  assign ordy[0] = r0; assign ordy[1] = r1; assign ordy[2] = r2;
  assign ob[0] = b0;  assign ob[1] = b1;  assign ob[2] = b2;
  assign osat[0] = t0; assign osat[1] = t1; assign osat[2] = t2;
  assign os[0] = {49'd0, s0};
  assign os[1] = {49'd0, s1};
  assign os[2] = s2;
  assign ocnt[0] = {16'd0, c0};
  assign ocnt[1] = {28'd0, c1};
  assign ocnt[2] = {16'd0, c2};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    case (k)
      0:       return L0;
      1:       return L1;
      default: return L2;
    endcase
  endfunction

  function automatic logic [63:0] mask_of(input int k);
    int w;
    w = (k == 2) ? W2 : ((k == 1) ? W1 : W0);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [31:0] cmax_of(input int k);
    int c;
    c = (k == 2) ? C2 : ((k == 1) ? C1 : C0);
    return (32'd1 << c) - 32'd1;
  endfunction

  // Arithmetic reference: unsigned compare, then pick the result by mode.
  function automatic void ref_sub(input logic [63:0] a_in, input logic [63:0] b_in,
                                  input logic [1:0] md, input logic [63:0] m,
                                  output logic [63:0] s, output logic br, output logic st);
    logic [63:0] x, y;
    x  = a_in & m;
    y  = b_in & m;
    br = x > y;
    st = 1'b0;
    case (md)
      2'd1: begin
        s  = br ? 64'd0 : ((y - x) & m);
        st = br;
      end
      2'd2:    s = br ? (x - y) : (y - x);
      default: s = (y - x) & m;
    endcase
  endfunction

  // Expected-result FIFOs, one per instance, and the expected counter value.
  logic [63:0] q_s [3][256];
  logic        q_b [3][256];
  logic        q_t [3][256];
  int          head [3];
  int          tail [3];
  int          n_del [3];
  logic [31:0] m_cnt [3];
  logic        in_reset = 1'b1;

  always @(posedge clk) begin
    logic [63:0] s;
    logic        br, st;
    in_reset = rst;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        head[k]  = 0;
        tail[k]  = 0;
        m_cnt[k] = 32'd0;
      end else begin
        if (ov[k] && out_ready && (head[k] != tail[k])) begin
          if (q_b[k][head[k] % 256] && (m_cnt[k] != cmax_of(k))) m_cnt[k] = m_cnt[k] + 32'd1;
          head[k]  = head[k] + 1;
          n_del[k] = n_del[k] + 1;
        end
        if (cnt_clr) m_cnt[k] = 32'd0;
        if (in_valid && ordy[k]) begin
          ref_sub(a, b, mode, mask_of(k), s, br, st);
          q_s[k][tail[k] % 256] = s;
          q_b[k][tail[k] % 256] = br;
          q_t[k][tail[k] % 256] = st;
          tail[k] = tail[k] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (in_reset) begin
        check($sformatf("u%0d_rst_valid", k), ov[k], 0);
        check($sformatf("u%0d_rst_ready", k), ordy[k], 1);
        check($sformatf("u%0d_rst_cnt", k), ocnt[k], 0);
      end else begin
        check($sformatf("u%0d_ready_rule", k), ordy[k], !ov[k] || out_ready);
        check($sformatf("u%0d_cnt", k), ocnt[k], m_cnt[k]);
        if (ov[k]) begin
          if (head[k] == tail[k]) begin
            check($sformatf("u%0d_spurious_valid", k), ov[k], 0);
          end else begin
            check($sformatf("u%0d_s", k), os[k], q_s[k][head[k] % 256]);
            check($sformatf("u%0d_borrow", k), ob[k], q_b[k][head[k] % 256]);
            check($sformatf("u%0d_sat", k), osat[k], q_t[k][head[k] % 256]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single pair into an idle pipe; u0 has one stage, so its result is visible after one edge.
  task automatic send0(input string tag, input logic [63:0] ai, input logic [63:0] bi,
                       input logic [1:0] md, input logic [63:0] es, input logic eb, input logic et);
    a = ai; b = bi; mode = md; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_valid"}, v0, 1);
    check({tag, "_s"}, os[0], es);
    check({tag, "_borrow"}, b0, eb);
    check({tag, "_sat"}, t0, et);
  endtask

  task automatic wait_v2(input string tag);
    int n;
    n = 0;
    while (!v2 && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_arrived"}, v2, 1);
  endtask

  initial begin
    int  i;
    bit  acc;
    int  start;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    mode = 2'd0; a = '0; b = '0;
    repeat (2) tick();
    check("reset_valid", v0, 0);
    check("reset_s", os[0], 0);
    check("reset_borrow", b0, 0);
    check("reset_sat", t0, 0);
    check("reset_cnt", ocnt[0], 0);
    check("reset_ready", r0, 1);
    rst = 1'b0;
    tick();

    // Latency: one pair, iReady high; each instance shows it exactly after LATENCY edges.
    a = 64'd5; b = 64'd3; mode = 2'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      for (int k = 0; k < 3; k++) check($sformatf("u%0d_latency_c%0d", k, c), ov[k], c == lat_of(k));
      if (c == 1) begin
        check("wrap_s", os[0], 64'h7FFE);
        check("wrap_borrow", b0, 1);
        check("wrap_sat", t0, 0);
      end
      tick();
    end

    send0("sat_5_3", 5, 3, 2'd1, 0, 1, 1);
    send0("abs_5_3", 5, 3, 2'd2, 2, 1, 0);
    send0("rsvd_5_3", 5, 3, 2'd3, 64'h7FFE, 1, 0);
    for (int md = 0; md < 4; md++) send0($sformatf("pos_m%0d", md), 3, 5, 2'(md), 2, 0, 0);
    for (int md = 0; md < 4; md++) send0($sformatf("eq_m%0d", md), 64'h1234, 64'h1234, 2'(md), 0, 0, 0);
    repeat (6) tick();

    // Back-pressure on the three-stage instance: stall downstream for cycles 4..6.
    i = 0;
    start = n_del[1];
    for (int cyc = 0; cyc < 60 && (i < 8 || head[1] != tail[1]); cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (i < 8);
      a = 64'(i); b = 64'(i + 10); mode = 2'd0;
      #1;
      if (!out_ready && v1) check("bp_ready_low", r1, 0);
      if (v1 && out_ready) check("bp_value", os[1], 10);
      acc = in_valid && r1;
      tick();
      if (acc) i++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_sent", i, 8);
    check("bp_delivered", 64'(n_del[1] - start), 8);
    repeat (6) tick();

    // Counter saturation on the 4-bit counter, then clear against a same-cycle borrow delivery.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    a = 64'd5; b = 64'd3; mode = 2'd0; in_valid = 1'b1;
    repeat (20) tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("cnt_saturated", ocnt[1], 15);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 10 && !v1; n++) tick();
    check("clr_pending_borrow", b1, 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("cnt_clr_priority", ocnt[1], 0);
    repeat (6) tick();

    // Reset while three pairs are in flight in the four-stage instance.
    a = 64'd7; b = 64'd9; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      check("flush_no_valid", v2, 0);
      tick();
    end
    a = 64'd1; b = 64'd2; mode = 2'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_v2("post_rst");
    check("post_rst_s", os[2], 1);
    repeat (6) tick();

    // 64-bit extremes.
    a = '1; b = 64'd0; mode = 2'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_v2("w64_wrap");
    check("w64_wrap_s", os[2], 1);
    check("w64_wrap_borrow", b2, 1);
    repeat (6) tick();
    a = '1; b = 64'd0; mode = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_v2("w64_abs");
    check("w64_abs_s", os[2], 64'hFFFF_FFFF_FFFF_FFFF);
    check("w64_abs_borrow", b2, 1);
    repeat (6) tick();

    // Random traffic with random back-pressure, modes and occasional counter clears.
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 31) == 0);
      mode      = 2'($urandom_range(0, 3));
      a         = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       b = a;
        1:       begin b = {$urandom, $urandom}; a = '0; end
        2:       b = ~a;
        3:       begin b = '0; a = '1; end
        default: b = {$urandom, $urandom};
      endcase
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < 3; k++) check($sformatf("u%0d_drained", k), 64'(tail[k] - head[k]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
